// File: rtl/opr1_pkg.sv
// Shared definitions for the group-1 operate sequencer.
// Holds the sequencer state encoding, the rotater operation codes and
// the IR bit positions of the individual micro-operations.
package opr1_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_CLR  = 3'd1,
        S_CMP  = 3'd2,
        S_INC  = 3'd3,
        S_ROT  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Rotater operation codes driven on ROT_OP.
    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] BSW = 3'b001;
    localparam logic [2:0] RAL = 3'b010;
    localparam logic [2:0] RTL = 3'b011;
    localparam logic [2:0] RAR = 3'b100;
    localparam logic [2:0] RTR = 3'b101;

    // Group-1 opcode field value in IR[11:8].
    localparam logic [3:0] GRP1_OPC = 4'b1110;

    // Micro-operation bit positions within IR.
    localparam int unsigned BIT_CLA = 7;
    localparam int unsigned BIT_CLL = 6;
    localparam int unsigned BIT_CMA = 5;
    localparam int unsigned BIT_CML = 4;
    localparam int unsigned BIT_RAR = 3;
    localparam int unsigned BIT_RAL = 2;
    localparam int unsigned BIT_TWO = 1;   // doubles a rotate, or BSW alone
    localparam int unsigned BIT_IAC = 0;

endpackage

// File: rtl/opr1_sequencer.sv
// Sequences a PDP-8 style group-1 operate instruction: CLA/CLL, CMA/CML, IAC, rotate.
// Latency: group-1 START to DONE is 5 cycles; any other instruction is 1 cycle.
// No backpressure: START is only accepted in IDLE and ignored while BUSY.
// Ports: CLK/RESET (sync, active-high); START/IR/AC_IN/L_IN request;
//        ROT_* connect to an external rotater peer; AC_OUT/L_OUT working regs;
//        BUSY/DONE status.
// Build option: define OPR1_BSW_EN to issue the byte-swap (BSW) rotater code.
module opr1_sequencer
    import opr1_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [11:0] IR,
    input  logic [11:0] AC_IN,
    input  logic        L_IN,
    output logic [2:0]  ROT_OP,
    output logic [11:0] ROT_AI,
    output logic        ROT_LI,
    output logic        ROT_OE,
    input  logic [11:0] ROT_AO,
    input  logic        ROT_LO,
    output logic [11:0] AC_OUT,
    output logic        L_OUT,
    output logic        BUSY,
    output logic        DONE
);

    state_t      state;
    logic [7:0]  ir_q;      // only the micro-op field is needed after acceptance
    logic [11:0] ac;
    logic        l;
    logic [12:0] inc_sum;   // bit 12 is the carry-out of AC+1

    assign inc_sum = {1'b0, ac} + 13'd1;

    // Map the rotate bits onto a rotater code.
    function automatic logic [2:0] rot_decode(input logic [7:0] op);
        logic [2:0] code;
        code = NOP;
        case ({op[BIT_RAR], op[BIT_RAL]})
            2'b10:   code = op[BIT_TWO] ? RTR : RAR;
            2'b01:   code = op[BIT_TWO] ? RTL : RAL;
            2'b00: begin
`ifdef OPR1_BSW_EN
                code = op[BIT_TWO] ? BSW : NOP;
`else
                // Byte swap unavailable: the rotater passes AC/L through.
                code = NOP;
`endif
            end
            default: code = NOP;   // conflicting rotate directions
        endcase
        return code;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            ir_q   <= '0;
            ac     <= '0;
            l      <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ROT_OE <= 1'b0;
            ROT_OP <= NOP;
        end else begin
            case (state)
                IDLE: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b0;
                    if (START) begin
                        ir_q <= IR[7:0];
                        ac   <= AC_IN;
                        l    <= L_IN;
                        BUSY <= 1'b1;
                        if (IR[11:8] == GRP1_OPC) begin
                            state <= S_CLR;
                        end else begin
                            // Not ours: complete immediately, registers unchanged.
                            state <= S_DONE;
                            DONE  <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    if (ir_q[BIT_CLA]) ac <= '0;
                    if (ir_q[BIT_CLL]) l  <= 1'b0;
                    state <= S_CMP;
                end
                S_CMP: begin
                    if (ir_q[BIT_CMA]) ac <= ~ac;
                    if (ir_q[BIT_CML]) l  <= ~l;
                    state <= S_INC;
                end
                S_INC: begin
                    if (ir_q[BIT_IAC]) begin
                        ac <= inc_sum[11:0];
                        l  <= l ^ inc_sum[12];
                    end
                    // Rotater controls are registered, so arm them on entry to S_ROT.
                    ROT_OE <= 1'b1;
                    ROT_OP <= rot_decode(ir_q);
                    state  <= S_ROT;
                end
                S_ROT: begin
                    ac     <= ROT_AO;
                    l      <= ROT_LO;
                    ROT_OE <= 1'b0;
                    ROT_OP <= NOP;
                    DONE   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    // START here is deliberately dropped; it is honoured next cycle.
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    BUSY   <= 1'b0;
                    DONE   <= 1'b0;
                    ROT_OE <= 1'b0;
                    ROT_OP <= NOP;
                end
            endcase
        end
    end

    assign ROT_AI = ac;
    assign ROT_LI = l;
    assign AC_OUT = ac;
    assign L_OUT  = l;

endmodule

// File: tb/tb_opr1_sequencer.sv
module tb_opr1_sequencer;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [11:0] IR;
    logic [11:0] AC_IN;
    logic        L_IN;
    logic [2:0]  ROT_OP;
    logic [11:0] ROT_AI;
    logic        ROT_LI;
    logic        ROT_OE;
    logic [11:0] ROT_AO;
    logic        ROT_LO;
    logic [11:0] AC_OUT;
    logic        L_OUT;
    logic        BUSY;
    logic        DONE;

    int checks;
    int failures;

    opr1_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .IR     (IR),
        .AC_IN  (AC_IN),
        .L_IN   (L_IN),
        .ROT_OP (ROT_OP),
        .ROT_AI (ROT_AI),
        .ROT_LI (ROT_LI),
        .ROT_OE (ROT_OE),
        .ROT_AO (ROT_AO),
        .ROT_LO (ROT_LO),
        .AC_OUT (AC_OUT),
        .L_OUT  (L_OUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External rotater peer: rotates the 13-bit {L,AC} word.
    always_comb begin
        ROT_AO = ROT_AI;
        ROT_LO = ROT_LI;
        case (ROT_OP)
            3'b001: ROT_AO = {ROT_AI[5:0], ROT_AI[11:6]};
            3'b010: {ROT_LO, ROT_AO} = {ROT_AI, ROT_LI};
            3'b011: {ROT_LO, ROT_AO} = {ROT_AI[10:0], ROT_LI, ROT_AI[11]};
            3'b100: {ROT_LO, ROT_AO} = {ROT_AI[0], ROT_LI, ROT_AI[11:1]};
            3'b101: {ROT_LO, ROT_AO} = {ROT_AI[1], ROT_AI[0], ROT_LI, ROT_AI[11:2]};
            default: ;
        endcase
    end

    // Issue one instruction and follow it to DONE (bounded at 20 cycles).
    // lat is the cycle index of DONE counted from the accepting edge.
    task automatic run_op(input logic [11:0] ir, input logic [11:0] ac, input logic l,
                          output int lat, output logic [11:0] ac_res, output logic l_res,
                          output int oe_n, output int oe_at, output logic [2:0] op_seen,
                          output int stray);
        START = 1'b1; IR = ir; AC_IN = ac; L_IN = l;
        lat = 0; oe_n = 0; oe_at = 0; op_seen = 3'b111; stray = 0;
        do begin
            @(posedge CLK); #1;
            START = 1'b0;
            lat++;
            if (ROT_OE === 1'b1) begin
                oe_n++;
                oe_at = lat;
                op_seen = ROT_OP;
            end else if (ROT_OP !== 3'b000) begin
                stray++;
            end
        end while (DONE !== 1'b1 && lat < 20);
        ac_res = AC_OUT;
        l_res  = L_OUT;
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b1; IR = 12'o7200; AC_IN = 12'o1234; L_IN = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || ROT_OE !== 1'b0 || ROT_OP !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b oe=%b op=%b want 0 0 0 000", BUSY, DONE, ROT_OE, ROT_OP);
        end
        checks++;
        if (AC_OUT !== 12'o0000 || L_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs ac=%o l=%b want 0000 0", AC_OUT, L_OUT);
        end
        RESET = 1'b0; START = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_priority busy=%b want 0", BUSY);
        end
    endtask

    task automatic test_clear;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        run_op(12'o7200, 12'o1234, 1'b1, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (lat != 5) begin failures++; $display("FAIL cla_latency got=%0d want=5", lat); end
        checks++;
        if (a !== 12'o0000 || lo !== 1'b1) begin
            failures++; $display("FAIL cla_result ac=%o l=%b want 0000 1", a, lo);
        end
        checks++;
        if (BUSY !== 1'b1) begin failures++; $display("FAIL busy_in_done got=%b want 1", BUSY); end
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL return_idle done=%b busy=%b want 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_iac;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        run_op(12'o7001, 12'o7777, 1'b0, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (a !== 12'o0000 || lo !== 1'b1 || lat != 5) begin
            failures++; $display("FAIL iac_wrap ac=%o l=%b lat=%0d want 0000 1 5", a, lo, lat);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_ral;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        run_op(12'o7004, 12'o4000, 1'b0, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (oe_n != 1 || oe_at != 4 || op !== 3'b010) begin
            failures++; $display("FAIL ral_oe oe_cycles=%0d at=%0d op=%b want 1 4 010", oe_n, oe_at, op);
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL ral_op_outside got=%0d want 0", stray); end
        checks++;
        if (a !== 12'o0000 || lo !== 1'b1) begin
            failures++; $display("FAIL ral_result ac=%o l=%b want 0000 1", a, lo);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_rtr;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        run_op(12'o7012, 12'o0003, 1'b0, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (op !== 3'b101) begin failures++; $display("FAIL rtr_op got=%b want 101", op); end
        checks++;
        if (a !== 12'o4000 || lo !== 1'b1) begin
            failures++; $display("FAIL rtr_result ac=%o l=%b want 4000 1", a, lo);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_bsw;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        logic [11:0] exp_ac; logic [2:0] exp_op;
`ifdef OPR1_BSW_EN
        exp_ac = 12'o7700; exp_op = 3'b001;
`else
        exp_ac = 12'o0077; exp_op = 3'b000;
`endif
        run_op(12'o7002, 12'o0077, 1'b0, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (op !== exp_op || oe_n != 1) begin
            failures++; $display("FAIL bsw_op got=%b oe_cycles=%0d want %b 1", op, oe_n, exp_op);
        end
        checks++;
        if (a !== exp_ac || lo !== 1'b0) begin
            failures++; $display("FAIL bsw_result ac=%o l=%b want %o 0", a, lo, exp_ac);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_nongroup;
        int lat, oe_n, oe_at, stray; logic [11:0] a; logic lo; logic [2:0] op;
        run_op(12'o5000, 12'o1234, 1'b1, lat, a, lo, oe_n, oe_at, op, stray);
        checks++;
        if (lat != 1 || oe_n != 0) begin
            failures++; $display("FAIL nongroup_latency lat=%0d oe_cycles=%0d want 1 0", lat, oe_n);
        end
        checks++;
        if (a !== 12'o1234 || lo !== 1'b1) begin
            failures++; $display("FAIL nongroup_result ac=%o l=%b want 1234 1", a, lo);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid;
        int dones;
        START = 1'b1; IR = 12'o7001; AC_IN = 12'o1234; L_IN = 1'b1;
        @(posedge CLK); #1; START = 1'b0;   // S_CLR
        @(posedge CLK); #1;                 // S_CMP
        @(posedge CLK); #1;                 // S_INC
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || AC_OUT !== 12'o0000 || L_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b ac=%o l=%b want 0 0 0000 0", BUSY, DONE, AC_OUT, L_OUT);
        end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL reset_mid_abort activity=%0d want 0", dones); end
    endtask

    task automatic test_start_while_busy;
        int lat;
        START = 1'b1; IR = 12'o7001; AC_IN = 12'o7777; L_IN = 1'b0;
        @(posedge CLK); #1; START = 1'b0;   // cycle 1
        @(posedge CLK); #1;                 // cycle 2
        START = 1'b1; IR = 12'o7040; AC_IN = 12'o1111; L_IN = 1'b1;
        @(posedge CLK); #1; START = 1'b0;   // cycle 3
        lat = 3;
        while (DONE !== 1'b1 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        checks++;
        if (lat != 5 || AC_OUT !== 12'o0000 || L_OUT !== 1'b1) begin
            failures++; $display("FAIL busy_start lat=%0d ac=%o l=%b want 5 0000 1", lat, AC_OUT, L_OUT);
        end
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL busy_start_queued busy=%b want 0", BUSY); end
    endtask

    task automatic test_back_to_back;
        int lat;
        START = 1'b1; IR = 12'o5000; AC_IN = 12'o1234; L_IN = 1'b1;
        @(posedge CLK); #1;                 // cycle 1: S_DONE
        checks++;
        if (DONE !== 1'b1) begin failures++; $display("FAIL b2b_first_done got=%b want 1", DONE); end
        START = 1'b1; IR = 12'o7200; AC_IN = 12'o4321; L_IN = 1'b0;
        @(posedge CLK); #1;                 // cycle 2: IDLE, START in S_DONE dropped
        checks++;
        if (BUSY !== 1'b0 || AC_OUT !== 12'o1234) begin
            failures++; $display("FAIL b2b_done_ignore busy=%b ac=%o want 0 1234", BUSY, AC_OUT);
        end
        @(posedge CLK); #1;                 // cycle 3: accepted from IDLE
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || AC_OUT !== 12'o4321) begin
            failures++; $display("FAIL b2b_accept busy=%b ac=%o want 1 4321", BUSY, AC_OUT);
        end
        lat = 1;
        while (DONE !== 1'b1 && lat < 20) begin
            @(posedge CLK); #1;
            lat++;
        end
        checks++;
        if (lat != 5 || AC_OUT !== 12'o0000 || L_OUT !== 1'b0) begin
            failures++; $display("FAIL b2b_result lat=%0d ac=%o l=%b want 5 0000 0", lat, AC_OUT, L_OUT);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        RESET = 1'b1; START = 1'b0; IR = '0; AC_IN = '0; L_IN = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_clear();
        test_iac();
        test_ral();
        test_rtr();
        test_bsw();
        test_nongroup();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opr1_sequencer.md
OPR1_SEQUENCER -- requirements
Module: opr1_sequencer

Interface
REQ-001 The port list SHALL be exactly as follows; one clock, reset synchronous and active-high.
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request to execute the instruction on IR.
- IR  in  12  instruction word, sampled on accepted START.
- AC_IN  in  12  accumulator value, sampled on accepted START.
- L_IN  in  1  link value, sampled on accepted START.
- ROT_OP  out  3  rotate code driven to the rotater.
- ROT_AI  out  12  working AC driven to the rotater.
- ROT_LI  out  1  working link driven to the rotater.
- ROT_OE  out  1  rotater output enable.
- ROT_AO  in  12  rotater AC result.
- ROT_LO  in  1  rotater link result.
- AC_OUT  out  12  working AC register.
- L_OUT  out  1  working link register.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle completion pulse.

Function
REQ-002 States SHALL be IDLE, S_CLR, S_CMP, S_INC, S_ROT and S_DONE, one cycle each, advancing unconditionally in that order.
REQ-003 In IDLE, START SHALL latch IR, AC_IN and L_IN and enter S_CLR; START in any other state SHALL be ignored.
REQ-004 An instruction is group 1 when IR[11:8]==4'b1110; a non-group-1 instruction SHALL go IDLE->S_DONE with AC and L unchanged.
REQ-005 S_CLR SHALL clear AC if IR[7] (CLA) and clear L if IR[6] (CLL).
REQ-006 S_CMP SHALL complement AC if IR[5] (CMA) and complement L if IR[4] (CML).
REQ-007 S_INC, if IR[0] (IAC), SHALL set AC=AC+1 modulo 4096 and complement L on carry-out (AC 7777 -> 0000, L inverted).
REQ-008 ROT_OP decode: IR[3] only -> 100 (RAR), or 101 if IR[1] (RTR); IR[2] only -> 010 (RAL), or 011 if IR[1] (RTL); neither with IR[1] -> 001 (BSW); both IR[3] and IR[2] -> 000.
REQ-009 In S_ROT, ROT_OE SHALL be 1, ROT_OP SHALL carry the decoded code, and AC/L SHALL load ROT_AO/ROT_LO at the cycle end.
REQ-010 Outside S_ROT, ROT_OE SHALL be 0 and ROT_OP SHALL be 000.
REQ-011 ROT_AI and ROT_LI SHALL continuously mirror the AC and L registers.
REQ-012 BUSY SHALL be 1 in S_CLR through S_DONE.
REQ-013 DONE SHALL be 1 only in S_DONE, after which the block returns to IDLE.
REQ-014 Group-1 latency from START to DONE SHALL be 5 cycles; non-group-1 latency SHALL be 1 cycle.
REQ-015 START asserted in the S_DONE cycle SHALL be ignored; START in the next cycle (IDLE) SHALL be accepted.

Reset
REQ-016 RESET SHALL force IDLE and clear AC, L, the latched IR, BUSY, DONE and ROT_OE to 0 on the next edge, including mid-sequence.
REQ-017 RESET SHALL take priority over a simultaneous START.

Configuration
REQ-018 With OPR1_BSW_EN defined, the 001 (BSW) code SHALL be issued per REQ-008.
REQ-019 Without OPR1_BSW_EN, an IR[1] request with neither rotate bit SHALL produce ROT_OP=000 (AC and L pass through); RTL and RTR are unaffected.

Structure
REQ-020 A shared package opr1_pkg SHALL hold the state enumeration, the ROT_OP code constants (NOP, BSW, RAL, RTL, RAR, RTR) and the IR bit-position constants.
REQ-021 No internal sub-module SHALL be used; the rotater remains an external peer connected via the ROT_* ports.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- IR=7200, AC_IN=1234, L_IN=1 -> AC_OUT=0000, L_OUT=1, DONE 5 cycles after START.
- IR=7001, AC_IN=7777, L_IN=0 -> AC_OUT=0000, L_OUT=1.
- IR=7004, AC_IN=4000, L_IN=0 -> ROT_OP=010 with ROT_OE=1 in S_ROT only; result AC_OUT=0000, L_OUT=1.
- IR=7012, AC_IN=0003, L_IN=0 -> ROT_OP=101; result AC_OUT=4000, L_OUT=1.
- IR=7002, AC_IN=0077 -> AC_OUT=7700 with OPR1_BSW_EN; AC_OUT=0077 and ROT_OP=000 without it.
- RESET asserted in S_INC -> next cycle BUSY=0, DONE=0, AC_OUT=0000, L_OUT=0.
- START pulsed while BUSY -> no effect on the sequence or its result.
